// File: rtl/rolling_threshold_pkg.sv
// Shared types and width helpers for the rolling threshold monitor.
//   state_t          : controller states
//   chunk_width()    : width of one per-channel chunk accumulator
//   total_width()    : width of one per-channel window total
//   fifo_word_width(): width of one history FIFO word (all channels)
package rolling_threshold_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_RUNNING,
    ST_TRIPPED,
    ST_ERROR
  } state_t;

  function automatic int chunk_width(input int sample_w, input int chunk_log2_max);
    return sample_w + chunk_log2_max;
  endfunction

  function automatic int total_width(input int sample_w, input int chunk_log2_max,
                                     input int fifo_addr_w);
    return chunk_width(sample_w, chunk_log2_max) + fifo_addr_w + 1;
  endfunction

  function automatic int fifo_word_width(input int num_ch, input int chunk_w);
    return num_ch * chunk_w;
  endfunction

endpackage

// File: rtl/rolling_threshold_monitor_fifo_sync.sv
// Synchronous single-clock FIFO with registered read data.
//   clk, resetn : clock, synchronous active-low reset (pointers and count)
//   wr_en/wr_data : push; accepted when not full, or when full with a pop
//   rd_en/rd_data : pop; rd_data is valid the cycle after rd_en
//   full, empty   : occupancy flags
module fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
    if (do_rd) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rolling_threshold_monitor.sv
// Multi-channel rolling-window integrator with latched over-threshold trip.
// Each channel sums decimated absolute samples into chunks; a history FIFO of
// chunk words lets a per-channel window total be kept exactly. A channel trips
// when its total exceeds threshold_average * window_chunks << chunk_log2.
//   clk, resetn        : clock, synchronous active-low reset
//   enable             : start configuration (sampled in IDLE)
//   clear              : return to IDLE and zero sums/flags (FIFO not reset)
//   chunk_log2         : log2 of decimated samples per chunk
//   window_chunks      : window length in chunks
//   threshold_average  : per-sample average threshold
//   ch_mask            : live per-channel trip enable
//   sample_core_done   : sample source ready
//   abs_sample_concat  : channel i at [(i+1)*SAMPLE_W-1 -: SAMPLE_W]
//   setup_done, over_thresh, trip_mask, err_config, err_overflow : status
module rolling_threshold_monitor
  import rolling_threshold_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int SAMPLE_W       = 15,
  parameter int DECIM_LOG2     = 4,
  parameter int CHUNK_LOG2_MAX = 8,
  parameter int FIFO_ADDR_W    = 10
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [4:0]                   chunk_log2,
  input  logic [FIFO_ADDR_W:0]         window_chunks,
  input  logic [SAMPLE_W-1:0]          threshold_average,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic                         sample_core_done,
  input  logic [NUM_CH*SAMPLE_W-1:0]   abs_sample_concat,
  output logic                         setup_done,
  output logic                         over_thresh,
  output logic [NUM_CH-1:0]            trip_mask,
  output logic                         err_config,
  output logic                         err_overflow
);

  localparam int CHUNK_W = chunk_width(SAMPLE_W, CHUNK_LOG2_MAX);
  localparam int TOTAL_W = total_width(SAMPLE_W, CHUNK_LOG2_MAX, FIFO_ADDR_W);
  localparam int WORD_W  = fifo_word_width(NUM_CH, CHUNK_W);

  localparam logic [FIFO_ADDR_W:0] WIN_MAX = {1'b1, {FIFO_ADDR_W{1'b0}}};
  localparam logic [4:0]           CL2_MAX = 5'(CHUNK_LOG2_MAX);

  state_t state, state_next;

  logic [4:0]                chunk_log2_r;
  logic [FIFO_ADDR_W:0]      window_r;
  logic [TOTAL_W-1:0]        mcand;
  logic [SAMPLE_W-1:0]       mplier;
  logic [TOTAL_W-1:0]        max_value;
  logic [DECIM_LOG2-1:0]     decim_cnt;
  logic [CHUNK_LOG2_MAX-1:0] chunk_cnt;
  logic [CHUNK_LOG2_MAX-1:0] chunk_last;
  logic [FIFO_ADDR_W:0]      fill;

  logic              zero_all;
  logic              cfg_bad;
  logic              mplier_last;
  logic              running;
  logic              draining;
  logic              tick;
  logic              acc_p0;
  logic              chunk_end_p0;
  logic              pop_p0;
  logic              overflow_p0;
  logic [WORD_W-1:0] wr_word;
  logic              vld_p1;
  logic              popped_p1;
  logic [WORD_W-1:0] word_p1;
  logic              upd_p1;
  logic              vld_p2;
  logic [NUM_CH-1:0] cmp_p2;
  logic              trip_p2;

  logic              fifo_wr_en;
  logic              fifo_rd_en;
  logic [WORD_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;

  assign zero_all    = !resetn || clear;
  assign cfg_bad     = (window_chunks == '0) || (window_chunks > WIN_MAX) ||
                       (chunk_log2 > CL2_MAX);
  assign mplier_last = ((mplier >> 1) == '0);
  assign running     = (state == ST_RUNNING);
  assign draining    = (state == ST_IDLE) || (state == ST_SETUP) || (state == ST_WAIT);
  assign chunk_last  = ~({CHUNK_LOG2_MAX{1'b1}} << chunk_log2_r);

  // Stage p0: decimation tick, chunk end, FIFO push/pop decision
  assign tick         = (decim_cnt == '0);
  assign acc_p0       = running && tick;
  assign chunk_end_p0 = acc_p0 && (chunk_cnt == chunk_last);
  assign pop_p0       = (fill == window_r);
  assign overflow_p0  = chunk_end_p0 && fifo_full && !pop_p0;

  // Words left behind by a clear are discarded before the next run starts.
  assign fifo_wr_en = !clear && chunk_end_p0 && !overflow_p0;
  assign fifo_rd_en = !clear && ((chunk_end_p0 && pop_p0) || (draining && !fifo_empty));

  // Stage p1: window total update from new chunk and popped chunk
  assign upd_p1 = running && vld_p1;

  // Stage p2: strict compare against max_value, gated by the live mask
  assign trip_p2 = running && vld_p2 && (|cmp_p2);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SAMPLE_W-1:0] sample;
    logic [CHUNK_W-1:0]  chunk_sum;
    logic [CHUNK_W-1:0]  chunk_next;
    logic [CHUNK_W-1:0]  new_p1;
    logic [CHUNK_W-1:0]  old_p1;
    logic [TOTAL_W-1:0]  total;

    assign sample     = abs_sample_concat[(i+1)*SAMPLE_W-1 -: SAMPLE_W];
    assign chunk_next = chunk_sum + CHUNK_W'(sample);
    assign wr_word[(i+1)*CHUNK_W-1 -: CHUNK_W] = chunk_next;
    assign new_p1     = word_p1[(i+1)*CHUNK_W-1 -: CHUNK_W];
    assign old_p1     = fifo_rd_data[(i+1)*CHUNK_W-1 -: CHUNK_W];
    assign cmp_p2[i]  = (total > max_value) && ch_mask[i];

    always_ff @(posedge clk) begin
      if (zero_all) begin
        chunk_sum <= '0;
        total     <= '0;
      end else begin
        if (acc_p0) chunk_sum <= chunk_end_p0 ? '0 : chunk_next;
        if (upd_p1) total <= total + TOTAL_W'(new_p1) - (popped_p1 ? TOTAL_W'(old_p1) : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (enable) state_next = cfg_bad ? ST_ERROR : ST_SETUP;
      ST_SETUP:   if (mplier_last) state_next = ST_WAIT;
      ST_WAIT:    if (sample_core_done && fifo_empty) state_next = ST_RUNNING;
      ST_RUNNING: begin
        if (overflow_p0)  state_next = ST_ERROR;
        else if (trip_p2) state_next = ST_TRIPPED;
      end
      default: ;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (zero_all) begin
      chunk_log2_r <= '0;
      window_r     <= '0;
      mcand        <= '0;
      mplier       <= '0;
      max_value    <= '0;
      decim_cnt    <= '0;
      chunk_cnt    <= '0;
      fill         <= '0;
      vld_p1       <= 1'b0;
      popped_p1    <= 1'b0;
      word_p1      <= '0;
      vld_p2       <= 1'b0;
      setup_done   <= 1'b0;
      over_thresh  <= 1'b0;
      trip_mask    <= '0;
      err_config   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            chunk_log2_r <= chunk_log2;
            window_r     <= window_chunks;
            mcand        <= TOTAL_W'(window_chunks) << chunk_log2;
            mplier       <= threshold_average;
            max_value    <= '0;
            if (cfg_bad) err_config <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (mplier[0]) max_value <= max_value + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        ST_WAIT: begin
          if (state_next == ST_RUNNING) begin
            setup_done <= 1'b1;
            decim_cnt  <= '0;
            chunk_cnt  <= '0;
          end
        end
        ST_RUNNING: begin
          decim_cnt <= decim_cnt + DECIM_LOG2'(1);
          if (tick) chunk_cnt <= chunk_end_p0 ? '0 : chunk_cnt + CHUNK_LOG2_MAX'(1);
          if (overflow_p0) err_overflow <= 1'b1;
          else if (chunk_end_p0 && !pop_p0) fill <= fill + (FIFO_ADDR_W+1)'(1);
          vld_p1 <= chunk_end_p0 && !overflow_p0;
          if (chunk_end_p0) begin
            word_p1   <= wr_word;
            popped_p1 <= pop_p0;
          end
          vld_p2 <= vld_p1;
          if (trip_p2) begin
            over_thresh <= 1'b1;
            trip_mask   <= cmp_p2;
          end
        end
        default: ;
      endcase
    end
  end

  fifo_sync #(
    .DATA_WIDTH(WORD_W),
    .ADDR_WIDTH(FIFO_ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_en  (fifo_wr_en),
    .wr_data(wr_word),
    .rd_en  (fifo_rd_en),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule
